maxnet_engine: RTL and testbench

Parametrised fixed-point MAXNET (iterative winner-take-all) engine: N signed channels and an inhibition weight are captured on `start`. The engine iterates x_i ← ReLU(x_i + eps·Σ_{j≠i} x_j) until at most one channel is non-zero or an iteration limit is hit. It then reports the surviving index and value. It is the generalised successor of the 4-input floating-point Maxnet model: N, width and fraction bits are parameters, arithmetic is fixed-point with one time-shared multiplier, and it adds timeout and no-winner detection.

---
 rtl/maxnet_engine_if.sv | 30 +++
 rtl/maxnet_engine.sv | 165 ++++++++++++++++
 tb/tb_maxnet_engine.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/maxnet_engine_if.sv
// Handshake and result bundle for the MAXNET winner-take-all engine.
// The master side (requester) drives start/eps/x_in; the engine side returns status and results.
interface maxnet_engine_if #(
    parameter int N  = 4,
    parameter int W  = 16,
    parameter int IW = 8
);
    localparam int NW = $clog2(N);

    logic            start;
    logic [W-1:0]    eps;
    logic [N*W-1:0]  x_in;
    logic            busy;
    logic            done;
    logic [NW-1:0]   winner_idx;
    logic [W-1:0]    winner_val;
    logic [IW-1:0]   iter_count;
    logic            timeout;
    logic            no_winner;

    modport master (
        output start, eps, x_in,
        input  busy, done, winner_idx, winner_val, iter_count, timeout, no_winner
    );

    modport slave (
        input  start, eps, x_in,
        output busy, done, winner_idx, winner_val, iter_count, timeout, no_winner
    );
endinterface

// File: rtl/maxnet_engine.sv
// Fixed-point MAXNET engine: channels repeatedly inhibit each other through one shared
// multiplier until at most one survives or the iteration limit is reached.
module maxnet_engine #(
    parameter int N        = 4,
    parameter int W        = 16,
    parameter int FRAC     = 8,
    parameter int MAX_ITER = 255
) (
    input  logic             clk,
    input  logic             rst,
    maxnet_engine_if.slave   bus
);
    localparam int IW   = 8;
    localparam int KW   = $clog2(N);
    localparam int CW   = $clog2(N + 1);
    localparam int SW   = W + $clog2(N);
    localparam int PW   = W + SW;
    localparam int SUMW = PW + 1;
    localparam logic [KW-1:0]          K_LAST = KW'(N - 1);
    localparam logic signed [SUMW-1:0] XMAX   = SUMW'((2 ** (W - 1)) - 1);

    typedef enum logic [2:0] {IDLE, LOAD, CHECK, SUM, UPDATE, DONE} state_t;

    state_t                 state;
    logic signed [W-1:0]    x [N];
    logic signed [W-1:0]    eps_r;
    logic signed [SW-1:0]   s;
    logic [KW-1:0]          k;
    logic                   busy_r;
    logic                   done_r;
    logic [KW-1:0]          winner_idx_r;
    logic [W-1:0]           winner_val_r;
    logic [IW-1:0]          iter_r;
    logic                   timeout_r;
    logic                   no_winner_r;

    logic signed [W-1:0]    xk;
    logic signed [SW-1:0]   d;
    logic signed [PW-1:0]   prod;
    logic signed [PW-1:0]   p;
    logic signed [SUMW-1:0] sum;
    logic signed [W-1:0]    x_next;
    logic [CW-1:0]          nz;
    logic [KW-1:0]          best_idx;
    logic signed [W-1:0]    best_val;

    // Update datapath for channel k; the shift floors toward minus infinity.
    always_comb begin
        xk   = x[k];
        d    = s - SW'(xk);
        prod = PW'(eps_r) * PW'(d);
        p    = prod >>> FRAC;
        sum  = SUMW'(xk) + SUMW'(p);
        if (sum < 0)
            x_next = '0;
        else if (sum > XMAX)
            x_next = XMAX[W-1:0];
        else
            x_next = sum[W-1:0];
    end

    // Strict greater-than keeps the lowest index on ties; all-zero yields index 0.
    always_comb begin
        nz       = '0;
        best_idx = '0;
        best_val = '0;
        for (int i = 0; i < N; i++) begin
            if (x[i] != '0)
                nz = nz + CW'(1);
            if (x[i] > best_val) begin
                best_val = x[i];
                best_idx = KW'(i);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            eps_r        <= '0;
            s            <= '0;
            k            <= '0;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
            winner_idx_r <= '0;
            winner_val_r <= '0;
            iter_r       <= '0;
            timeout_r    <= 1'b0;
            no_winner_r  <= 1'b0;
            for (int i = 0; i < N; i++)
                x[i] <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        eps_r  <= bus.eps;
                        for (int i = 0; i < N; i++)
                            x[i] <= bus.x_in[i*W +: W];
                        busy_r <= 1'b1;
                        state  <= LOAD;
                    end
                end
                LOAD: begin
                    for (int i = 0; i < N; i++)
                        if (x[i][W-1])
                            x[i] <= '0;
                    iter_r       <= '0;
                    timeout_r    <= 1'b0;
                    no_winner_r  <= 1'b0;
                    winner_idx_r <= '0;
                    winner_val_r <= '0;
                    state        <= CHECK;
                end
                CHECK: begin
                    // Results are registered here so they are valid alongside the done pulse.
                    if (nz <= CW'(1) || iter_r == IW'(MAX_ITER)) begin
                        done_r       <= 1'b1;
                        busy_r       <= 1'b0;
                        winner_idx_r <= best_idx;
                        winner_val_r <= best_val;
                        no_winner_r  <= (nz == '0);
                        timeout_r    <= (nz > CW'(1));
                        state        <= DONE;
                    end else begin
                        s     <= '0;
                        k     <= '0;
                        state <= SUM;
                    end
                end
                SUM: begin
                    s <= s + SW'(xk);
                    if (k == K_LAST) begin
                        k     <= '0;
                        state <= UPDATE;
                    end else begin
                        k <= k + KW'(1);
                    end
                end
                UPDATE: begin
                    x[k] <= x_next;
                    if (k == K_LAST) begin
                        k      <= '0;
                        iter_r <= iter_r + IW'(1);
                        state  <= CHECK;
                    end else begin
                        k <= k + KW'(1);
                    end
                end
                DONE: begin
                    done_r <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.busy       = busy_r;
    assign bus.done       = done_r;
    assign bus.winner_idx = winner_idx_r;
    assign bus.winner_val = winner_val_r;
    assign bus.iter_count = iter_r;
    assign bus.timeout    = timeout_r;
    assign bus.no_winner  = no_winner_r;
endmodule

// File: tb/tb_maxnet_engine.sv
// Directed bench for maxnet_engine: one default instance and one with a 2-iteration limit.
// Expected values are hand-derived from the Q8.8 update rule.
module tb_maxnet_engine;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   total = 0;
    int   bad   = 0;
    int   edges;

    always #5 clk = ~clk;

    maxnet_engine_if #(.N(4), .W(16), .IW(8)) bus_a ();
    maxnet_engine_if #(.N(4), .W(16), .IW(8)) bus_b ();

    maxnet_engine #(.N(4), .W(16), .FRAC(8), .MAX_ITER(255)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (bus_a)
    );

    maxnet_engine #(.N(4), .W(16), .FRAC(8), .MAX_ITER(2)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (bus_b)
    );

    task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Start is sampled at "edge 0"; returns at the negedge after that edge.
    task automatic apply_stimulus(input bit use_b, input logic [15:0] e, input logic [63:0] xv);
        @(negedge clk);
        if (use_b) begin
            bus_b.start = 1'b1; bus_b.eps = e; bus_b.x_in = xv;
        end else begin
            bus_a.start = 1'b1; bus_a.eps = e; bus_a.x_in = xv;
        end
        @(negedge clk);
        bus_a.start = 1'b0;
        bus_b.start = 1'b0;
    endtask

    // Counts edges after edge 0 until done; optionally pulses a stray start at edge poke_at.
    task automatic wait_done(input bit use_b, input int budget, input int poke_at, output int n);
        n = 0;
        while (!(use_b ? bus_b.done : bus_a.done) && n < budget) begin
            @(negedge clk);
            n++;
            if (n == poke_at) begin
                bus_a.start = 1'b1;
                bus_a.x_in  = {16'h0100, 16'h7000, 16'h0200, 16'h0300};
            end else begin
                bus_a.start = 1'b0;
            end
        end
        check_output("done_seen", use_b ? 32'(bus_b.done) : 32'(bus_a.done), 32'd1);
    endtask

    task automatic check_result(input bit use_b, input string tag, input int exp_edges, input int got_edges,
                                input logic [31:0] idx, input logic [31:0] val, input logic [31:0] iter,
                                input logic [31:0] to, input logic [31:0] nw, input bit chk_iter);
        logic [31:0] held;
        if (exp_edges >= 0)
            check_output({tag, ".latency"}, 32'(got_edges), 32'(exp_edges));
        check_output({tag, ".idx"},  use_b ? 32'(bus_b.winner_idx) : 32'(bus_a.winner_idx), idx);
        check_output({tag, ".val"},  use_b ? 32'(bus_b.winner_val) : 32'(bus_a.winner_val), val);
        if (chk_iter)
            check_output({tag, ".iter"}, use_b ? 32'(bus_b.iter_count) : 32'(bus_a.iter_count), iter);
        check_output({tag, ".timeout"},   use_b ? 32'(bus_b.timeout)   : 32'(bus_a.timeout), to);
        check_output({tag, ".no_winner"}, use_b ? 32'(bus_b.no_winner) : 32'(bus_a.no_winner), nw);
        check_output({tag, ".busy_done"}, use_b ? 32'(bus_b.busy) : 32'(bus_a.busy), 32'd0);
        @(negedge clk);
        held = use_b ? 32'(bus_b.winner_val) : 32'(bus_a.winner_val);
        check_output({tag, ".done_pulse"}, use_b ? 32'(bus_b.done) : 32'(bus_a.done), 32'd0);
        check_output({tag, ".held_val"}, held, val);
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog observed=running expected=finished");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bus_a.start = 1'b0; bus_a.eps = '0; bus_a.x_in = '0;
        bus_b.start = 1'b0; bus_b.eps = '0; bus_b.x_in = '0;

        // Asynchronous reset between edges, with start held high throughout.
        #12;
        rst = 1'b1;
        bus_a.start = 1'b1;
        bus_a.x_in  = {16'h1400, 16'h0000, 16'hFB00, 16'h0A00};
        #1;
        check_output("rst.busy",       32'(bus_a.busy), 32'd0);
        check_output("rst.done",       32'(bus_a.done), 32'd0);
        check_output("rst.winner_idx", 32'(bus_a.winner_idx), 32'd0);
        check_output("rst.winner_val", 32'(bus_a.winner_val), 32'd0);
        check_output("rst.iter_count", 32'(bus_a.iter_count), 32'd0);
        check_output("rst.timeout",    32'(bus_a.timeout), 32'd0);
        check_output("rst.no_winner",  32'(bus_a.no_winner), 32'd0);
        check_output("rst.b_busy",     32'(bus_b.busy), 32'd0);
        repeat (2) @(negedge clk);
        bus_a.start = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        check_output("rst.start_ignored", 32'(bus_a.busy), 32'd0);

        // Nominal run: three iterations, channel 3 survives with 0x1053.
        apply_stimulus(1'b0, 16'hFFCD, {16'h1400, 16'h0000, 16'hFB00, 16'h0A00});
        check_output("nom.busy_load", 32'(bus_a.busy), 32'd1);
        wait_done(1'b0, 3000, -1, edges);
        check_result(1'b0, "nom", 29, edges, 32'd3, 32'h1053, 32'd3, 32'd0, 32'd0, 1'b1);

        // Only one positive channel after clamping: finishes straight from the first CHECK.
        apply_stimulus(1'b0, 16'hFFCD, {16'h0000, 16'h0780, 16'hFF00, 16'h0000});
        wait_done(1'b0, 3000, -1, edges);
        check_result(1'b0, "single", 2, edges, 32'd2, 32'h0780, 32'd0, 32'd0, 32'd0, 1'b1);

        // Tied channels decay in lockstep until both hit zero.
        apply_stimulus(1'b0, 16'hFFCD, {16'h0000, 16'h0000, 16'h0500, 16'h0500});
        wait_done(1'b0, 3000, -1, edges);
        check_result(1'b0, "tie", -1, edges, 32'd0, 32'd0, 32'd0, 32'd0, 32'd1, 1'b0);

        // Stray start during SUM must not disturb the nominal result.
        apply_stimulus(1'b0, 16'hFFCD, {16'h1400, 16'h0000, 16'hFB00, 16'h0A00});
        wait_done(1'b0, 3000, 3, edges);
        check_result(1'b0, "stray", 29, edges, 32'd3, 32'h1053, 32'd3, 32'd0, 32'd0, 1'b1);

        // Reset in the middle of UPDATE aborts without a done pulse; the next run is clean.
        apply_stimulus(1'b0, 16'hFFCD, {16'h1400, 16'h0000, 16'hFB00, 16'h0A00});
        repeat (7) @(negedge clk);
        rst = 1'b1;
        #1;
        check_output("abort.busy", 32'(bus_a.busy), 32'd0);
        check_output("abort.done", 32'(bus_a.done), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        apply_stimulus(1'b0, 16'hFFCD, {16'h1400, 16'h0000, 16'hFB00, 16'h0A00});
        wait_done(1'b0, 3000, -1, edges);
        check_result(1'b0, "rerun", 29, edges, 32'd3, 32'h1053, 32'd3, 32'd0, 32'd0, 1'b1);

        // Iteration limit of 2: values step 10,20,30,40 -> 9,19,29,39 -> 8,18,28,38.
        apply_stimulus(1'b1, 16'hFFFF, {16'd40, 16'd30, 16'd20, 16'd10});
        wait_done(1'b1, 3000, -1, edges);
        check_result(1'b1, "timeout", 20, edges, 32'd3, 32'd38, 32'd2, 32'd1, 32'd0, 1'b1);

        // Positive weight drives every channel to the upper clamp.
        apply_stimulus(1'b1, 16'h0100, {16'h0000, 16'h0000, 16'h7F00, 16'h7F00});
        wait_done(1'b1, 3000, -1, edges);
        check_result(1'b1, "sat", 20, edges, 32'd0, 32'h7FFF, 32'd2, 32'd1, 32'd0, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
